// File: rtl/id_issue_queue_pkg.sv
// Shared types and constants for the decode-side instruction queue.
// Instruction field layout follows the classic MIPS32 encoding.
package id_issue_queue_pkg;

    typedef logic [31:0] InstAddr_t;
    typedef logic [31:0] Inst_t;
    typedef logic [4:0]  RegAddr_t;

    localparam logic      RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [5:0] EXE_SPECIAL_INST  = 6'b000000;
    localparam logic [5:0] EXE_SPECIAL2_INST = 6'b011100;

    // SPECIAL funct codes touching HI/LO
    localparam logic [5:0] EXE_MFHI  = 6'b010000;
    localparam logic [5:0] EXE_MTHI  = 6'b010001;
    localparam logic [5:0] EXE_MFLO  = 6'b010010;
    localparam logic [5:0] EXE_MTLO  = 6'b010011;
    localparam logic [5:0] EXE_MULT  = 6'b011000;
    localparam logic [5:0] EXE_MULTU = 6'b011001;
    localparam logic [5:0] EXE_DIV   = 6'b011010;
    localparam logic [5:0] EXE_DIVU  = 6'b011011;

    // SPECIAL2 funct codes touching HI/LO
    localparam logic [5:0] EXE_MADD  = 6'b000000;
    localparam logic [5:0] EXE_MADDU = 6'b000001;
    localparam logic [5:0] EXE_MSUB  = 6'b000100;
    localparam logic [5:0] EXE_MSUBU = 6'b000101;

    typedef struct packed {
        InstAddr_t pc;
        Inst_t     inst;
    } IqEntry_t;

    // True when the instruction reads or writes HI/LO.
    function automatic logic is_hilo_op(input Inst_t inst);
        logic [5:0] op;
        logic [5:0] fn;
        op = inst[31:26];
        fn = inst[5:0];
        is_hilo_op = 1'b0;
        if (op == EXE_SPECIAL_INST) begin
            is_hilo_op = (fn == EXE_MFHI) || (fn == EXE_MFLO) || (fn == EXE_MTHI) ||
                         (fn == EXE_MTLO) || (fn == EXE_MULT) || (fn == EXE_MULTU) ||
                         (fn == EXE_DIV)  || (fn == EXE_DIVU);
        end else if (op == EXE_SPECIAL2_INST) begin
            is_hilo_op = (fn == EXE_MADD) || (fn == EXE_MADDU) ||
                         (fn == EXE_MSUB) || (fn == EXE_MSUBU);
        end
    endfunction

    // True for DIV / DIVU, which start the multi-cycle divider.
    function automatic logic is_div_op(input Inst_t inst);
        is_div_op = (inst[31:26] == EXE_SPECIAL_INST) &&
                    ((inst[5:0] == EXE_DIV) || (inst[5:0] == EXE_DIVU));
    endfunction

endpackage

// File: rtl/id_issue_queue_fifo.sv
// iq_fifo: generic first-word-fall-through FIFO with occupancy and flush.
// The head entry is shown combinationally from storage; empty shows zero.
module iq_fifo
    import id_issue_queue_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = IqEntry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  T                             i_data,
    input  logic                         i_pop,
    output T                             o_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~w_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign o_count   = r_count;

    // Pointers and occupancy; flush empties the queue, pointers wrap mod DEPTH.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Head entry, zero (NOP) when empty.
    always_comb begin
        o_data = '0;
        if (!o_empty) o_data = r_mem[r_rd_ptr];
    end

endmodule

// File: rtl/id_issue_queue.sv
// id_issue_queue: instruction queue between IF and decode with issue
// interlock for load-use and HI/LO-while-dividing hazards.
// Optional macro IQ_BYPASS_EN: an instruction offered to an empty queue is
// presented to decode in the same cycle.
//
// Handshakes: on the IF side an entry transfers on a rising edge where
// if_valid_i & if_ready_o; on the decode side the head transfers on a rising
// edge where id_valid_o & !stall_i. Neither valid waits on its ready.
module id_issue_queue
    import id_issue_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DIV_CYCLES = 33,
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         if_valid_i,
    input  logic [ADDR_W-1:0]            if_pc_i,
    input  logic [INST_W-1:0]            if_inst_i,
    output logic                         if_ready_o,
    input  logic                         flush_i,
    input  logic                         stall_i,
    input  logic                         ex_wreg_i,
    input  RegAddr_t                     ex_wd_i,
    input  logic                         ex_is_load_i,
    output logic                         id_valid_o,
    output logic [ADDR_W-1:0]            id_pc_o,
    output logic [INST_W-1:0]            id_inst_o,
    output logic                         hazard_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         hilo_busy_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DIV_W = $clog2(DIV_CYCLES + 1);

    // Same layout as IqEntry_t, sized by this instance's widths.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t            w_in_entry;
    entry_t            w_fifo_head;
    entry_t            w_head;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_bypass;
    logic              w_head_present;
    logic              w_load_use;
    logic              w_hilo_hazard;
    logic              w_pop;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic              w_head_is_div;
    RegAddr_t          w_rs;
    RegAddr_t          w_rt;
    logic [DIV_W-1:0]  r_div_cnt;

    assign w_in_entry = '{pc: if_pc_i, inst: if_inst_i};

`ifdef IQ_BYPASS_EN
    assign w_bypass = w_fifo_empty & if_valid_i & ~flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    // Head mux: storage when occupied, else the bypassed IF offer, else NOP.
    always_comb begin
        w_head = '0;
        if (!w_fifo_empty) w_head = w_fifo_head;
        else if (w_bypass) w_head = w_in_entry;
    end

    assign w_head_present = ~w_fifo_empty | w_bypass;
    assign w_rs           = w_head.inst[25:21];
    assign w_rt           = w_head.inst[20:16];
    assign w_head_is_div  = is_div_op(Inst_t'(w_head.inst));

    // Both register fields are treated as sources regardless of opcode.
    assign w_load_use    = ex_is_load_i & ex_wreg_i & (ex_wd_i != '0) &
                           ((ex_wd_i == w_rs) | (ex_wd_i == w_rt));
    assign w_hilo_hazard = (r_div_cnt != '0) & is_hilo_op(Inst_t'(w_head.inst));

    assign hazard_o    = w_head_present & (w_load_use | w_hilo_hazard);
    assign id_valid_o  = w_head_present & ~hazard_o;
    assign id_pc_o     = w_head.pc;
    assign id_inst_o   = w_head.inst;
    assign if_ready_o  = (w_fifo_count != CNT_W'(DEPTH)) & ~flush_i;
    assign count_o     = w_fifo_count;
    assign hilo_busy_o = (r_div_cnt != '0);

    assign w_pop       = id_valid_o & ~stall_i;
    // A bypassed instruction consumed this cycle never enters storage.
    assign w_fifo_push = if_valid_i & if_ready_o & ~(w_bypass & w_pop);
    assign w_fifo_pop  = w_pop & ~w_bypass;

    iq_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush_i),
        .i_push  (w_fifo_push),
        .i_data  (w_in_entry),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Divide busy countdown; survives flush since the divide in flight finishes.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_div_cnt <= '0;
        end else if (w_pop && !flush_i && w_head_is_div) begin
            r_div_cnt <= DIV_W'(DIV_CYCLES);
        end else if (r_div_cnt != '0) begin
            r_div_cnt <= r_div_cnt - DIV_W'(1);
        end
    end

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_id_issue_queue;

    localparam int DEPTH      = 4;
    localparam int DIV_CYCLES = 33;
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] I_ADDU = 32'h0041_1821; // ADDU $3,$2,$1
    localparam logic [31:0] I_DIV  = 32'h0043_001A; // DIV  $2,$3
    localparam logic [31:0] I_MFLO = 32'h0000_2012; // MFLO $4

    logic        clk;
    logic        rst;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        if_ready_o;
    logic        flush_i;
    logic        stall_i;
    logic        ex_wreg_i;
    logic [4:0]  ex_wd_i;
    logic        ex_is_load_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        hazard_o;
    logic [2:0]  count_o;
    logic        hilo_busy_o;

    int total;
    int bad;

    id_issue_queue #(.DEPTH(DEPTH), .DIV_CYCLES(DIV_CYCLES), .ADDR_W(32), .INST_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid_i   (if_valid_i),
        .if_pc_i      (if_pc_i),
        .if_inst_i    (if_inst_i),
        .if_ready_o   (if_ready_o),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .ex_wreg_i    (ex_wreg_i),
        .ex_wd_i      (ex_wd_i),
        .ex_is_load_i (ex_is_load_i),
        .id_valid_o   (id_valid_o),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o),
        .hazard_o     (hazard_o),
        .count_o      (count_o),
        .hilo_busy_o  (hilo_busy_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_hilo(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] fn;
        op = inst[31:26];
        fn = inst[5:0];
        if (op == 6'h00) return fn inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
        if (op == 6'h1C) return fn inside {6'h00, 6'h01, 6'h04, 6'h05};
        return 1'b0;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [63:0] exp_q[$];     // {pc, inst} in program order
    int          m_div;
    bit          m_ok;
    int          m_sz;
    bit          m_byp, m_present, m_lu, m_hl, m_haz, m_val, m_pop, m_push;
    logic [63:0] m_head;

    // Check DUT outputs against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_div = 0;
            m_ok  = 1'b1;
        end else if (m_ok) begin
            m_sz      = exp_q.size();
            m_byp     = BYP && (m_sz == 0) && if_valid_i && !flush_i;
            m_present = (m_sz > 0) || m_byp;
            m_head    = (m_sz > 0) ? exp_q[0] : (m_byp ? {if_pc_i, if_inst_i} : 64'd0);
            m_lu      = ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
                        ((ex_wd_i == m_head[25:21]) || (ex_wd_i == m_head[20:16]));
            m_hl      = (m_div != 0) && m_hilo(m_head[31:0]);
            m_haz     = m_present && (m_lu || m_hl);
            m_val     = m_present && !m_haz;

            chk("model id_valid", {63'd0, id_valid_o}, {63'd0, m_val});
            chk("model hazard", {63'd0, hazard_o}, {63'd0, m_haz});
            chk("model id_pc", {32'd0, id_pc_o}, {32'd0, m_head[63:32]});
            chk("model id_inst", {32'd0, id_inst_o}, {32'd0, m_head[31:0]});
            chk("model count", {61'd0, count_o}, 64'(m_sz));
            chk("model if_ready", {63'd0, if_ready_o}, {63'd0, (m_sz != DEPTH) && !flush_i});
            chk("model hilo_busy", {63'd0, hilo_busy_o}, {63'd0, m_div != 0});

            m_pop  = m_val && !stall_i;
            m_push = if_valid_i && (m_sz != DEPTH) && !flush_i;
            if (flush_i) begin
                exp_q.delete();
                if (m_div > 0) m_div--;
            end else begin
                if (m_pop && m_head[31:26] == 6'h00 && (m_head[5:0] == 6'h1A || m_head[5:0] == 6'h1B))
                    m_div = DIV_CYCLES;
                else if (m_div > 0)
                    m_div--;
                if (m_pop && m_sz > 0) exp_q.pop_front();
                if (m_push && !(m_byp && m_pop)) exp_q.push_back({if_pc_i, if_inst_i});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] got[$];
    int          held;
    int          busy_n;
    bit          done;
    bit          acc;
    int          k;
    int          guard;

    initial begin
        total = 0; bad = 0; m_ok = 1'b0; m_div = 0;
        rst = 1'b1; if_valid_i = 0; if_pc_i = 0; if_inst_i = 0; flush_i = 0; stall_i = 0;
        ex_wreg_i = 0; ex_wd_i = 0; ex_is_load_i = 0;
        repeat (2) cyc();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst count", {61'd0, count_o}, 64'd0);
        chk("rst if_ready", {63'd0, if_ready_o}, 64'd1);
        chk("rst id_valid", {63'd0, id_valid_o}, 64'd0);
        chk("rst hazard", {63'd0, hazard_o}, 64'd0);
        chk("rst hilo_busy", {63'd0, hilo_busy_o}, 64'd0);
        chk("rst id_pc", {32'd0, id_pc_o}, 64'd0);
        cyc();

        // Fill under stall, attempt a push when full, then drain in order
        stall_i = 1;
        for (int i = 0; i < 4; i++) begin
            if_valid_i = 1; if_pc_i = 32'h100 + 4 * i; if_inst_i = 32'h1000 + i;
            cyc();
        end
        if_pc_i = 32'h999; if_inst_i = 32'h1999;
        @(negedge clk);
        chk("full count", {61'd0, count_o}, 64'd4);
        chk("full if_ready", {63'd0, if_ready_o}, 64'd0);
        cyc();
        if_valid_i = 0; stall_i = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain valid", {63'd0, id_valid_o}, 64'd1);
            chk("drain pc", {32'd0, id_pc_o}, 64'h100 + 4 * i);
            cyc();
        end
        @(negedge clk);
        chk("drained count", {61'd0, count_o}, 64'd0);
        chk("drained valid", {63'd0, id_valid_o}, 64'd0);
        cyc();

        // Load-use interlock on rs/rt, none on rd or $0
        ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd2; stall_i = 1;
        if_valid_i = 1; if_pc_i = 32'h180; if_inst_i = I_ADDU;
        cyc();
        if_valid_i = 0;
        @(negedge clk);
        chk("lu rs hazard", {63'd0, hazard_o}, 64'd1);
        chk("lu rs valid", {63'd0, id_valid_o}, 64'd0);
        cyc(); ex_wd_i = 5'd1;
        @(negedge clk); chk("lu rt hazard", {63'd0, hazard_o}, 64'd1);
        cyc(); ex_wd_i = 5'd3;
        @(negedge clk); chk("lu rd no hazard", {63'd0, hazard_o}, 64'd0);
        chk("lu rd valid", {63'd0, id_valid_o}, 64'd1);
        cyc(); ex_wd_i = 5'd0;
        @(negedge clk); chk("lu r0 no hazard", {63'd0, hazard_o}, 64'd0);
        cyc(); ex_wd_i = 5'd2; ex_wreg_i = 0;
        @(negedge clk); chk("lu nowreg no hazard", {63'd0, hazard_o}, 64'd0);
        cyc(); ex_wreg_i = 1; stall_i = 0;
        @(negedge clk);
        chk("lu held valid", {63'd0, id_valid_o}, 64'd0);
        chk("lu held count", {61'd0, count_o}, 64'd1);
        cyc(); ex_is_load_i = 0;
        @(negedge clk);
        chk("lu release valid", {63'd0, id_valid_o}, 64'd1);
        chk("lu release pc", {32'd0, id_pc_o}, 64'h180);
        cyc(); ex_wreg_i = 0; ex_wd_i = 0;
        @(negedge clk); chk("lu popped count", {61'd0, count_o}, 64'd0);
        cyc();

        // DIV then MFLO: MFLO held for DIV_CYCLES cycles
        stall_i = 1;
        if_valid_i = 1; if_pc_i = 32'h300; if_inst_i = I_DIV;  cyc();
        if_pc_i = 32'h304; if_inst_i = I_MFLO; cyc();
        if_valid_i = 0; stall_i = 0;
        @(negedge clk);
        chk("div issue pc", {32'd0, id_pc_o}, 64'h300);
        chk("div issue valid", {63'd0, id_valid_o}, 64'd1);
        cyc();
        held = 0; done = 0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            if (id_valid_o) done = 1;
            else begin held++; cyc(); end
        end
        chk("mflo wait finished", {63'd0, done}, 64'd1);
        chk("mflo held cycles", 64'(held), 64'd33);
        chk("mflo pc", {32'd0, id_pc_o}, 64'h304);
        chk("mflo busy clear", {63'd0, hilo_busy_o}, 64'd0);
        cyc();

        // DIV, ADDU, MFLO: ADDU issues while busy, MFLO waits one cycle less
        stall_i = 1;
        if_valid_i = 1; if_pc_i = 32'h310; if_inst_i = I_DIV;  cyc();
        if_pc_i = 32'h314; if_inst_i = I_ADDU; cyc();
        if_pc_i = 32'h318; if_inst_i = I_MFLO; cyc();
        if_valid_i = 0; stall_i = 0;
        @(negedge clk); chk("div2 pc", {32'd0, id_pc_o}, 64'h310);
        cyc();
        @(negedge clk);
        chk("addu busy", {63'd0, hilo_busy_o}, 64'd1);
        chk("addu valid", {63'd0, id_valid_o}, 64'd1);
        chk("addu pc", {32'd0, id_pc_o}, 64'h314);
        cyc();
        held = 0; done = 0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            if (id_valid_o) done = 1;
            else begin held++; cyc(); end
        end
        chk("mflo2 wait finished", {63'd0, done}, 64'd1);
        chk("mflo2 held cycles", 64'(held), 64'd32);
        chk("mflo2 pc", {32'd0, id_pc_o}, 64'h318);
        cyc();

        // Flush a full queue with a simultaneous push; divide keeps counting
        if_valid_i = 1; if_pc_i = 32'h400; if_inst_i = I_DIV; cyc();
        if_valid_i = 0; cyc();
        stall_i = 1;
        for (int i = 0; i < 4; i++) begin
            if_valid_i = 1; if_pc_i = 32'h500 + 4 * i; if_inst_i = 32'h1000 + i;
            cyc();
        end
        flush_i = 1; if_pc_i = 32'h510;
        @(negedge clk);
        chk("flush pre count", {61'd0, count_o}, 64'd4);
        chk("flush if_ready", {63'd0, if_ready_o}, 64'd0);
        cyc();
        flush_i = 0; if_valid_i = 0; stall_i = 0;
        @(negedge clk);
        chk("flush post count", {61'd0, count_o}, 64'd0);
        chk("flush post valid", {63'd0, id_valid_o}, 64'd0);
        busy_n = 0; done = 0;
        for (int n = 0; n < 60 && !done; n++) begin
            if (!hilo_busy_o) done = 1;
            else begin busy_n++; cyc(); @(negedge clk); end
        end
        chk("flush div drained", {63'd0, done}, 64'd1);
        chk("flush div remaining", 64'(busy_n), BYP ? 64'd27 : 64'd28);
        cyc();

        // Wrap-around: 3*DEPTH+1 entries with random stall
        k = 0; guard = 0;
        while (k < 3 * DEPTH + 1 && guard < 300) begin
            if_valid_i = 1; if_pc_i = 32'h600 + 4 * k; if_inst_i = 32'h2000 + k;
            stall_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = if_ready_o;
            if (id_valid_o && !stall_i) got.push_back(id_pc_o);
            cyc();
            if (acc) k++;
            guard++;
        end
        if_valid_i = 0; stall_i = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (id_valid_o) got.push_back(id_pc_o);
            cyc();
        end
        chk("wrap issued count", 64'(got.size()), 64'(3 * DEPTH + 1));
        for (int i = 0; i < got.size() && i < 3 * DEPTH + 1; i++)
            chk("wrap order", {32'd0, got[i]}, 64'h600 + 4 * i);

        // Bypass / first-issue latency from an empty queue
        if_valid_i = 1; if_pc_i = 32'h200; if_inst_i = I_ADDU; stall_i = 0;
        @(negedge clk);
`ifdef IQ_BYPASS_EN
        chk("byp same-cycle valid", {63'd0, id_valid_o}, 64'd1);
        chk("byp same-cycle pc", {32'd0, id_pc_o}, 64'h200);
        cyc();
        if_valid_i = 0;
        @(negedge clk);
        chk("byp count stays 0", {61'd0, count_o}, 64'd0);
        chk("byp nothing left", {63'd0, id_valid_o}, 64'd0);
`else
        chk("lat same-cycle valid", {63'd0, id_valid_o}, 64'd0);
        cyc();
        if_valid_i = 0;
        @(negedge clk);
        chk("lat next valid", {63'd0, id_valid_o}, 64'd1);
        chk("lat next pc", {32'd0, id_pc_o}, 64'h200);
        chk("lat next count", {61'd0, count_o}, 64'd1);
`endif
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
